// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encoding, the IF/ID bundle and the hold-buffer entry.
package fetch_pkg;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } hold_ent_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] insn;
    } if_id_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry word+pc buffer used to park a response during a stall.
// Ports: clk/rst, load/drain/clear controls, d in, full flag and q out.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      drain,
    input  logic      clear,
    input  hold_ent_t d,
    output logic      full,
    output hold_ent_t q
);

    logic      full_d, full_q;
    hold_ent_t ent_d, ent_q;

    always_comb begin
        full_d = full_q;
        ent_d  = ent_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            ent_d  = d;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            ent_q  <= '0;
        end else begin
            full_q <= full_d;
            ent_q  <= ent_d;
        end
    end

    assign full = full_q;
    assign q    = ent_q;

endmodule

// File: rtl/fetch.sv
// IF stage: owns the PC, single-outstanding imem requests, IF/ID register.
// Ports: clk/rst, keep/nop, branch redirect, imem req/resp, IF/ID outputs.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = INSN_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype
);

    if_state_e   state_d, state_q;
    logic [31:0] pc_d, pc_q;
    if_id_t      ifid_d, ifid_q;

    logic        accept;
    logic        keep_eff;
    logic        drain;
    logic        issue_ok;
    logic        issue;
    logic        hold_full;
    logic        hold_load;
    logic [31:0] acc_pc;
    hold_ent_t   hold_in, hold_q;

    // pc_q already points past the outstanding request while in WAIT
    assign acc_pc   = pc_q - 32'd4;
    assign accept   = (state_q == IF_WAIT) && imem_valid;
    assign keep_eff = keep && !nop && !branch_taken;
    assign drain    = hold_full && !branch_taken && !nop && !keep;

    // Only issue when the buffer ends the cycle empty, so a stall can
    // never meet a second response with nowhere to put it.
    assign issue_ok = !branch_taken && !keep_eff && (!hold_full || drain);
    assign issue    = !rst && issue_ok &&
                      ((state_q == IF_IDLE) || accept);

    assign hold_load = accept && keep_eff;
    assign hold_in   = '{pc: acc_pc, insn: imem_rdata};

    fetch_hold_buf u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .drain (drain),
        .clear (branch_taken),
        .d     (hold_in),
        .full  (hold_full),
        .q     (hold_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_IDLE: begin
                if (issue) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (branch_taken) begin
                    state_d = imem_valid ? IF_IDLE : IF_DROP;
                end else if (imem_valid) begin
                    state_d = issue ? IF_WAIT : IF_IDLE;
                end
            end
            IF_DROP: begin
                if (imem_valid) state_d = IF_IDLE;
            end
            default: state_d = IF_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target & ~32'd3;
        end else if (issue) begin
            pc_d = pc_inc(pc_q);
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        if (branch_taken || nop) begin
            ifid_d.insn = NOP_INSN;
        end else if (!keep) begin
            if (hold_full) begin
                ifid_d = '{pc:   hold_q.pc,
                           pcp4: pc_inc(hold_q.pc),
                           insn: hold_q.insn};
            end else if (accept) begin
                ifid_d = '{pc:   acc_pc,
                           pcp4: pc_inc(acc_pc),
                           insn: imem_rdata};
            end else begin
                ifid_d.insn = NOP_INSN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            ifid_q  <= '{pc: 32'd0, pcp4: 32'd0, insn: NOP_INSN};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign imem_req         = issue;
    assign imem_addr        = issue ? pc_q : 32'd0;
    assign PC_pype0         = ifid_q.pc;
    assign PCp4_pype0       = ifid_q.pcp4;
    assign Instraction_pype = ifid_q.insn;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: memory with programmable latency,
// stall, flush, redirect, wrap-around and mid-transaction reset.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep;
    logic        nop;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_pype0;
    logic [31:0] PCp4_pype0;
    logic [31:0] Instraction_pype;

    int errors = 0;
    int checks = 0;

    int          mem_lat = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_wait;

    fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSN (32'h0000_0013)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .keep             (keep),
        .nop              (nop),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_rdata       (imem_rdata),
        .PC_pype0         (PC_pype0),
        .PCp4_pype0       (PCp4_pype0),
        .Instraction_pype (Instraction_pype)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ifid(input string tag, input logic [31:0] pc,
                        input logic [31:0] p4, input logic [31:0] insn);
        chk({tag, "_pc"}, PC_pype0, pc);
        chk({tag, "_pcp4"}, PCp4_pype0, p4);
        chk({tag, "_insn"}, Instraction_pype, insn);
    endtask

    task automatic req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic noreq(input string tag);
        chk({tag, "_noreq"}, {31'd0, imem_req}, 32'd0);
    endtask

    // Ends the current cycle (recording any request), then applies the
    // controls and the memory response for the next cycle.
    task automatic tick(input logic r, input logic k, input logic n,
                        input logic b, input logic [31:0] t);
        if (imem_req === 1'b1) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_wait = mem_lat - 1;
        end
        @(posedge clk);
        #1;
        rst           = r;
        keep          = k;
        nop           = n;
        branch_taken  = b;
        branch_target = t;
        imem_valid    = 1'b0;
        imem_rdata    = 32'd0;
        if (pend) begin
            if (pend_wait == 0) begin
                imem_valid = 1'b1;
                imem_rdata = pend_addr ^ 32'hA5A5_0000;
                pend       = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        keep          = 1'b0;
        nop           = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        imem_valid    = 1'b0;
        imem_rdata    = 32'd0;

        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        ifid("rst", 32'd0, 32'd0, 32'h13);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // c0: first request right out of reset
        tick(0, 0, 0, 0, 0);
        req("c0", 32'h0);
        tick(0, 0, 0, 0, 0);
        req("c1", 32'h4);
        chk("c1_insn", Instraction_pype, 32'h13);
        tick(0, 0, 0, 0, 0);
        ifid("c2", 32'h0, 32'h4, 32'hA5A5_0000);
        req("c2", 32'h8);

        // stall while the response for 8 arrives
        tick(0, 1, 0, 0, 0);
        ifid("c3", 32'h4, 32'h8, 32'hA5A5_0004);
        noreq("c3");
        tick(0, 1, 0, 0, 0);
        ifid("c4", 32'h4, 32'h8, 32'hA5A5_0004);
        noreq("c4");
        tick(0, 1, 0, 0, 0);
        noreq("c5");
        tick(0, 0, 0, 0, 0);
        chk("c6_pc", PC_pype0, 32'h4);
        req("c6", 32'hC);
        tick(0, 0, 0, 0, 0);
        ifid("c7", 32'h8, 32'hC, 32'hA5A5_0008);
        req("c7", 32'h10);
        tick(0, 0, 0, 0, 0);
        ifid("c8", 32'hC, 32'h10, 32'hA5A5_000C);
        req("c8", 32'h14);

        // flush pulse
        tick(0, 0, 1, 0, 0);
        ifid("c9", 32'h10, 32'h14, 32'hA5A5_0010);
        req("c9", 32'h18);
        tick(0, 0, 0, 0, 0);
        ifid("c10", 32'h10, 32'h14, 32'h13);
        req("c10", 32'h1C);
        tick(0, 0, 0, 0, 0);
        ifid("c11", 32'h18, 32'h1C, 32'hA5A5_0018);
        req("c11", 32'h20);
        mem_lat = 3;

        // redirect while the request for 0x20 is outstanding
        tick(0, 0, 0, 1, 32'h100);
        ifid("c12", 32'h1C, 32'h20, 32'hA5A5_001C);
        noreq("c12");
        tick(0, 0, 0, 0, 0);
        chk("c13_insn", Instraction_pype, 32'h13);
        chk("c13_pc", PC_pype0, 32'h1C);
        noreq("c13");
        tick(0, 0, 0, 0, 0);
        chk("c14_insn", Instraction_pype, 32'h13);
        noreq("c14");
        mem_lat = 1;
        tick(0, 0, 0, 0, 0);
        req("c15", 32'h100);
        chk("c15_insn", Instraction_pype, 32'h13);
        tick(0, 0, 0, 0, 0);
        chk("c16_insn", Instraction_pype, 32'h13);
        req("c16", 32'h104);
        tick(0, 0, 0, 0, 0);
        ifid("c17", 32'h100, 32'h104, 32'hA5A5_0100);
        req("c17", 32'h108);

        // redirect and stall together, unaligned target
        tick(0, 1, 0, 1, 32'h203);
        ifid("c18", 32'h104, 32'h108, 32'hA5A5_0104);
        noreq("c18");
        tick(0, 0, 0, 0, 0);
        chk("c19_insn", Instraction_pype, 32'h13);
        req("c19", 32'h200);
        tick(0, 0, 0, 0, 0);
        req("c20", 32'h204);
        tick(0, 0, 0, 0, 0);
        ifid("c21", 32'h200, 32'h204, 32'hA5A5_0200);

        // wrap-around at the top of the address space
        tick(0, 0, 0, 1, 32'hFFFF_FFFC);
        ifid("c22", 32'h204, 32'h208, 32'hA5A5_0204);
        noreq("c22");
        tick(0, 0, 0, 0, 0);
        req("c23", 32'hFFFF_FFFC);
        chk("c23_insn", Instraction_pype, 32'h13);
        tick(0, 0, 0, 0, 0);
        req("c24", 32'h0);
        tick(0, 0, 0, 0, 0);
        ifid("c25", 32'hFFFF_FFFC, 32'h0, 32'h5A5A_FFFC);
        req("c25", 32'h4);
        mem_lat = 2;

        // reset while the request for 4 is outstanding
        tick(1, 0, 0, 0, 0);
        noreq("c26");
        chk("c26_addr", imem_addr, 32'h0);
        tick(0, 0, 0, 0, 0);
        ifid("c27", 32'h0, 32'h0, 32'h13);
        req("c27", 32'h0);
        mem_lat = 1;
        tick(0, 0, 0, 0, 0);
        ifid("c28", 32'h0, 32'h0, 32'h13);
        req("c28", 32'h4);
        tick(0, 0, 0, 0, 0);
        ifid("c29", 32'h0, 32'h4, 32'hA5A5_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
